// File: rtl/seq_scan_pkg.sv
// Shared types, default sizes and helpers for the serial scan controller.
package seq_scan_pkg;

   localparam int DEF_DATA_W  = 8;
   localparam int DEF_PAT_MAX = 8;
   localparam int DEF_CNT_W   = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // A length of 0 still means "compare one bit"; anything longer than the
   // history register is limited to the full history.
   function automatic int clamp_len(input int len, input int pat_max);
      if (len < 1)
         return 1;
      else if (len > pat_max)
         return pat_max;
      return len;
   endfunction

endpackage

// File: rtl/seq_pattern_matcher.sv
// Moore serial pattern matcher: keeps the most recent PAT_MAX bits and flags
// when the newest len bits equal the programmed pattern.
module seq_pattern_matcher
   import seq_scan_pkg::*;
#(
   parameter int PAT_MAX = DEF_PAT_MAX
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic                         shift_en,
   input  logic                         bit_in,
   input  logic [PAT_MAX-1:0]           pattern,
   input  logic [$clog2(PAT_MAX+1)-1:0] len,
   output logic                         match
);

   localparam int LEN_W = $clog2(PAT_MAX+1);

   logic [PAT_MAX-1:0] hist;
   logic [LEN_W-1:0]   nbits;
   logic               fresh;
   logic [PAT_MAX-1:0] mask;

   // Bit history; clear wins over a shift so the bit in flight is dropped.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         hist  <= '0;
         nbits <= '0;
         fresh <= 1'b0;
      end else begin
         fresh <= shift_en;
         if (shift_en) begin
            hist <= {hist[PAT_MAX-2:0], bit_in};
            if (nbits != LEN_W'(PAT_MAX))
               nbits <= nbits + 1'b1;
         end
      end
   end

   // Select the low len bits for comparison.
   always_comb begin
      mask = '0;
      for (int k = 0; k < PAT_MAX; k++)
         mask[k] = (k < int'(len));
   end

   assign match = fresh && (nbits >= len) && (((hist ^ pattern) & mask) == '0);

endmodule

// File: rtl/seq_scan_ctrl.sv
// Accepts words over valid/ready, serializes them MSB-first into the pattern
// matcher, counts detections and raises a sticky threshold interrupt.
module seq_scan_ctrl
   import seq_scan_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int PAT_MAX = DEF_PAT_MAX,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cfg_we,
   input  logic [PAT_MAX-1:0]           cfg_pattern,
   input  logic [$clog2(PAT_MAX+1)-1:0] cfg_len,
   input  logic [CNT_W-1:0]             cfg_thresh,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_W-1:0]            in_data,
   output logic                         bit_out,
   output logic                         busy,
   output logic                         match,
   output logic [CNT_W-1:0]             match_count,
   output logic                         irq,
   input  logic                         irq_clr
);

   localparam int LEN_W = $clog2(PAT_MAX+1);
   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   state_t             state, state_nxt;
   logic [DATA_W-1:0]  word;
   logic [IDX_W-1:0]   bit_idx;
   logic               last_bit;
   logic               accept;
   logic [PAT_MAX-1:0] pattern_q;
   logic [LEN_W-1:0]   len_q;
   logic [CNT_W-1:0]   thresh_q;
   logic [CNT_W-1:0]   cnt_inc;
   logic               irq_set;

   assign last_bit = (bit_idx == IDX_W'(DATA_W-1));
   assign accept   = in_valid && in_ready;
   assign bit_out  = busy && word[IDX_W'(DATA_W-1) - bit_idx];

   // Next state and handshake; in_ready depends only on state and bit_idx.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               state_nxt = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (last_bit) begin
               in_ready = 1'b1;
               if (!in_valid)
                  state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Serializer: load on handshake, otherwise step through the word.
   always_ff @(posedge clk) begin
      if (rst) begin
         word    <= '0;
         bit_idx <= '0;
      end else if (accept) begin
         word    <= in_data;
         bit_idx <= '0;
      end else if (busy) begin
         bit_idx <= last_bit ? '0 : bit_idx + 1'b1;
      end
   end

   // Configuration registers; length is clamped once on write.
   always_ff @(posedge clk) begin
      if (rst) begin
         pattern_q <= '0;
         len_q     <= LEN_W'(1);
         thresh_q  <= '0;
      end else if (cfg_we) begin
         pattern_q <= cfg_pattern;
         len_q     <= LEN_W'(clamp_len(int'(cfg_len), PAT_MAX));
         thresh_q  <= cfg_thresh;
      end
   end

   seq_pattern_matcher #(
      .PAT_MAX (PAT_MAX)
   ) u_matcher (
      .clk      (clk),
      .rst      (rst),
      .clear    (cfg_we),
      .shift_en (busy),
      .bit_in   (bit_out),
      .pattern  (pattern_q),
      .len      (len_q),
      .match    (match)
   );

   assign cnt_inc = (match_count == '1) ? match_count : match_count + 1'b1;
   assign irq_set = match && (thresh_q != '0) && (cnt_inc == thresh_q);

   // Saturating detection count and sticky irq; a set beats a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst || cfg_we) begin
         match_count <= '0;
         irq         <= 1'b0;
      end else begin
         if (match)
            match_count <= cnt_inc;
         if (irq_set)
            irq <= 1'b1;
         else if (irq_clr)
            irq <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: table of configurations/words with expected match
// cycles, plus reset and reconfiguration sequences.
module tb_seq_scan_ctrl;

   localparam int DATA_W  = 8;
   localparam int PAT_MAX = 8;
   localparam int CNT_W   = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic                cfg_we;
   logic [PAT_MAX-1:0]  cfg_pattern;
   logic [3:0]          cfg_len;
   logic [CNT_W-1:0]    cfg_thresh;
   logic                in_valid;
   logic                in_ready;
   logic [DATA_W-1:0]   in_data;
   logic                bit_out;
   logic                busy;
   logic                match;
   logic [CNT_W-1:0]    match_count;
   logic                irq;
   logic                irq_clr;

   seq_scan_ctrl #(
      .DATA_W  (DATA_W),
      .PAT_MAX (PAT_MAX),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_we      (cfg_we),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_thresh  (cfg_thresh),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .bit_out     (bit_out),
      .busy        (busy),
      .match       (match),
      .match_count (match_count),
      .irq         (irq),
      .irq_clr     (irq_clr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0]  pattern;
      logic [3:0]  len;
      logic [3:0]  thresh;
      bit          no_cfg;
      int          nw;
      logic [7:0]  w0;
      logic [7:0]  w1;
      logic [31:0] mask;    // bit j: match pulse expected in cycle T+j
      int          irq_at;  // first cycle offset with irq high, -1 never
      int          clr_at;  // cycle offset with irq_clr high, -1 never
   } vec_t;

   vec_t tbl [8];
   vec_t rst_vec;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   exp_q [$];
   int   t0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Sample mid-cycle; match is checked every cycle against the scoreboard.
   task automatic sample();
      logic e;
      @(negedge clk);
      e = (exp_q.size() > 0) && (exp_q[0] == cyc);
      if (e)
         void'(exp_q.pop_front());
      check("match", 32'(match), 32'(e));
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic [3:0] t);
      cfg_pattern = p;
      cfg_len     = l;
      cfg_thresh  = t;
      cfg_we      = 1'b1;
      sample();
      advance();
      cfg_we = 1'b0;
      sample();
      advance();
   endtask

   task automatic run_vec(input vec_t v);
      int         c;
      logic [7:0] w;
      if (!v.no_cfg)
         do_cfg(v.pattern, v.len, v.thresh);
      in_valid = 1'b1;
      in_data  = v.w0;
      t0       = cyc;
      for (int j = 0; j < 32; j++)
         if (v.mask[j])
            exp_q.push_back(t0 + j);
      for (int k = 0; k <= 8*v.nw + 3; k++) begin
         sample();
         check("in_ready", 32'(in_ready), 32'((k % 8 == 0) || (k > 8*v.nw)));
         check("busy", 32'(busy), 32'((k >= 1) && (k <= 8*v.nw)));
         if ((k >= 1) && (k <= 8*v.nw)) begin
            w = ((k-1)/8 == 0) ? v.w0 : v.w1;
            check("bit_out", 32'(bit_out), 32'(w[7 - ((k-1) % 8)]));
         end else begin
            check("bit_out", 32'(bit_out), 32'd0);
         end
         c = 0;
         for (int j = 0; j < k; j++)
            if (v.mask[j])
               c++;
         if (c > 15)
            c = 15;
         check("match_count", 32'(match_count), 32'(c));
         check("irq", 32'(irq), 32'((v.irq_at >= 0) && (k >= v.irq_at)));
         advance();
         if ((k % 8 == 0) && (k/8 < v.nw)) begin
            if (k/8 + 1 < v.nw)
               in_data = v.w1;
            else
               in_valid = 1'b0;
         end
         irq_clr = (k + 1 == v.clr_at);
      end
      irq_clr = 1'b0;
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      irq_clr = 1'b1;
      sample();
      advance();
      irq_clr = 1'b0;
      sample();
      check("irq_after_clr", 32'(irq), 32'd0);
      advance();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      //          pattern len    thr    nocfg nw w0     w1     mask          irq clr
      tbl[0] = '{8'h1D, 4'd5,  4'd0, 1'b0, 1, 8'hE8, 8'h00, 32'h0000_0040, -1, -1};
      tbl[1] = '{8'h1D, 4'd5,  4'd0, 1'b0, 2, 8'h07, 8'h40, 32'h0000_0800, -1, -1};
      tbl[2] = '{8'h05, 4'd3,  4'd3, 1'b0, 1, 8'hAA, 8'h00, 32'h0000_0150,  9,  8};
      tbl[3] = '{8'h01, 4'd1,  4'd0, 1'b0, 2, 8'hFF, 8'hFF, 32'h0003_FFFC, -1, 18};
      tbl[4] = '{8'h00, 4'd0,  4'd4, 1'b0, 1, 8'h0F, 8'h00, 32'h0000_003C,  6, -1};
      tbl[5] = '{8'hA5, 4'd15, 4'd2, 1'b0, 1, 8'hA5, 8'h00, 32'h0000_0200, -1, -1};
      tbl[6] = '{8'h03, 4'd2,  4'd2, 1'b0, 1, 8'hE0, 8'h00, 32'h0000_0018,  5, -1};
      tbl[7] = '{8'h00, 4'd8,  4'd0, 1'b0, 1, 8'h00, 8'h00, 32'h0000_0200, -1, -1};
      rst_vec = '{8'h00, 4'd1, 4'd0, 1'b1, 1, 8'hE8, 8'h00, 32'h0000_03A0, -1, -1};

      rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_thresh = '0;
      in_valid = 1'b0; in_data = '0; irq_clr = 1'b0;
      advance();
      advance();
      rst = 1'b0;
      sample();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_count", 32'(match_count), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_bit_out", 32'(bit_out), 32'd0);
      advance();

      for (int i = 0; i < 8; i++)
         run_vec(tbl[i]);

      // Reset in the middle of a word.
      do_cfg(8'h01, 4'd1, 4'd0);
      in_valid = 1'b1;
      in_data  = 8'hFF;
      t0       = cyc;
      exp_q.push_back(t0 + 2);
      exp_q.push_back(t0 + 3);
      exp_q.push_back(t0 + 4);
      sample();
      advance();
      in_valid = 1'b0;
      while (cyc < t0 + 4) begin
         sample();
         advance();
      end
      rst = 1'b1;
      sample();
      advance();
      rst = 1'b0;
      sample();
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_count", 32'(match_count), 32'd0);
      check("midrst_irq", 32'(irq), 32'd0);
      check("midrst_bit_out", 32'(bit_out), 32'd0);
      check("midrst_sb_empty", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      advance();
      run_vec(rst_vec);

      // Reconfiguration while a word is shifting.
      do_cfg(8'h01, 4'd1, 4'd2);
      in_valid = 1'b1;
      in_data  = 8'hFF;
      t0       = cyc;
      exp_q.push_back(t0 + 2);
      exp_q.push_back(t0 + 3);
      for (int j = 6; j <= 9; j++)
         exp_q.push_back(t0 + j);
      sample();
      advance();
      in_valid = 1'b0;
      while (cyc < t0 + 3) begin
         sample();
         advance();
      end
      cfg_pattern = 8'h03;
      cfg_len     = 4'd2;
      cfg_thresh  = 4'd1;
      cfg_we      = 1'b1;
      sample();
      advance();
      cfg_we = 1'b0;
      sample();
      check("recfg_count_cleared", 32'(match_count), 32'd0);
      check("recfg_irq_cleared", 32'(irq), 32'd0);
      advance();
      while (cyc < t0 + 7) begin
         sample();
         advance();
      end
      sample();
      check("recfg_count_first", 32'(match_count), 32'd1);
      check("recfg_irq_set", 32'(irq), 32'd1);
      advance();
      while (cyc < t0 + 12) begin
         sample();
         advance();
      end
      sample();
      check("recfg_count_final", 32'(match_count), 32'd4);
      check("recfg_irq_hold", 32'(irq), 32'd1);
      check("recfg_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
